// File: rtl/burst_line_adapter.sv
// Cacheline <-> memory burst bridge.
// One LINE_W-bit LLC read or write becomes BEATS = LINE_W/BURST_W memory beats.
// Each beat is acknowledged individually by resp_i, and acks may have gaps.
// The control outputs are decoded from the state register only.
module burst_line_adapter #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [LINE_W-1:0]   line_i,
   output logic [LINE_W-1:0]   line_o,
   input  logic [ADDR_W-1:0]   address_i,
   input  logic                read_i,
   input  logic                write_i,
   output logic                resp_o,
   input  logic [BURST_W-1:0]  burst_i,
   output logic [BURST_W-1:0]  burst_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                resp_i
);
   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [LINE_W-1:0]   wr_line;
   logic                last_beat;

   // The final beat of the burst is being acknowledged this cycle.
   assign last_beat = resp_i && (cnt == CNT_W'(BEATS - 1));

   // Burst sequencer: request acceptance, beat counting and read-line assembly.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         line_o    <= '0;
         wr_line   <= '0;
         address_o <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               // A read wins over a write when both are requested together.
               if (read_i) begin
                  state     <= READ;
                  cnt       <= '0;
                  line_o    <= '0;
                  address_o <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               end else if (write_i) begin
                  state     <= WRITE;
                  cnt       <= '0;
                  wr_line   <= line_i;
                  address_o <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               end
            end
            READ: begin
               if (resp_i) begin
                  for (int b = 0; b < BEATS; b++)
                     if (cnt == CNT_W'(b))
                        line_o[b*BURST_W +: BURST_W] <= burst_i;
                  cnt <= cnt + CNT_W'(1);
                  if (last_beat) state <= DONE;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  cnt <= cnt + CNT_W'(1);
                  if (last_beat) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign read_o  = (state == READ);
   assign write_o = (state == WRITE);
   assign resp_o  = (state == DONE);

   // Write beat mux: the captured line slice selected by the beat counter.
   // The output is zero outside a write burst.
   always_comb begin
      burst_o = '0;
      if (state == WRITE)
         for (int b = 0; b < BEATS; b++)
            if (cnt == CNT_W'(b))
               burst_o = wr_line[b*BURST_W +: BURST_W];
   end

endmodule

// File: tb/tb_burst_line_adapter.sv
// Scoreboard bench for burst_line_adapter.
// It runs two configurations: 256/64 (4 beats) and 512/64 (8 beats).
// The drivers push expectations derived from the protocol rules.
// Per-configuration monitors pop those expectations and compare them with the DUT.
module tb_burst_line_adapter;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int LW = (g == 0) ? 256 : 512;
      localparam int BW = 64;
      localparam int NB = LW / BW;

      logic            reset_n, read_i, write_i, resp_i;
      logic            resp_o, read_o, write_o;
      logic [LW-1:0]   line_i, line_o;
      logic [AW-1:0]   address_i, address_o;
      logic [BW-1:0]   burst_i, burst_o;
      bit              done = 1'b0;

      burst_line_adapter #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) u_dut (
         .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
         .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
         .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
         .read_o(read_o), .write_o(write_o), .resp_i(resp_i));

      typedef struct { bit rd; logic [LW-1:0] line; logic [AW-1:0] addr; int cyc; } resp_t;
      typedef struct { bit rd; int cyc; } start_t;

      resp_t         resp_q[$];
      start_t        start_q[$];
      logic [BW-1:0] beat_q[$];

      function automatic string nm(input string s);
         return $sformatf("L%0d_%s", LW, s);
      endfunction

      function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
         return AW'(a - a % AW'(LW / 8));
      endfunction

      function automatic logic [LW-1:0] rnd_line();
         logic [LW-1:0] r;
         for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
         return r;
      endfunction

      // mode 0: ack every cycle; 1: acks in burst cycles 1,3,4,7 then every cycle; 2: random acks
      function automatic bit ackpat(input int mode, input int k);
         if (mode == 1) return !(k == 2 || k == 5 || k == 6);
         if (mode == 2) return ($urandom_range(0, 2) != 0) || (k > 200);
         return 1'b1;
      endfunction

      // One complete transaction, starting in an IDLE cycle and ending at the next IDLE cycle.
      task automatic run(input bit rd, input bit both, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wl, input int mode);
         logic [LW-1:0] exp_line;
         logic [3:0]    nib;
         int            n, k;
         bit            a;
         resp_t         r;
         start_t        s;
         read_i    = rd;
         write_i   = !rd || both;
         address_i = addr;
         line_i    = wl;
         resp_i    = 1'($urandom);
         burst_i   = {$urandom, $urandom};
         s.rd = rd; s.cyc = cyc + 1;
         start_q.push_back(s);
         if (!rd) for (int i = 0; i < NB; i++) beat_q.push_back(wl[i*BW +: BW]);
         exp_line = '0; n = 0; k = 0;
         step();
         read_i = 1'b0;
         if (!both) write_i = 1'b0;
         while (n < NB) begin
            k++;
            a         = ackpat(mode, k);
            nib       = 4'(n + 1);
            resp_i    = a;
            burst_i   = (rd && mode == 0) ? {16{nib}} : {$urandom, $urandom};
            line_i    = rnd_line();
            address_i = $urandom;
            if (a) begin
               if (rd) exp_line[n*BW +: BW] = burst_i;
               n++;
               if (n == NB) begin
                  r.rd = rd; r.line = exp_line; r.addr = line_addr(addr); r.cyc = cyc + 1;
                  resp_q.push_back(r);
               end
            end
            step();
         end
         resp_i  = 1'($urandom);
         burst_i = {$urandom, $urandom};
         step();
         resp_i = 1'b0;
      endtask

      // Read aborted by reset after two acknowledged beats.
      task automatic abort_read(input logic [AW-1:0] addr);
         start_t s;
         read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
         s.rd = 1'b1; s.cyc = cyc + 1;
         start_q.push_back(s);
         step();
         read_i = 1'b0;
         for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            step();
         end
         resp_i = 1'b0; reset_n = 1'b0;
         step();
         reset_n = 1'b1;
         @(negedge clk);
         chk(nm("abort_read_o"), read_o, 0);
         chk(nm("abort_resp_o"), resp_o, 0);
         chk(nm("abort_line_o"), line_o, 0);
         step();
      endtask

      // Monitor: request start edges, write beats, completion pulses.
      logic   act_prev = 1'b0;
      start_t ms;
      resp_t  mr;
      always @(negedge clk) begin
         if (!write_o) chk(nm("burst_idle"), burst_o, 0);
         chk(nm("rw_excl"), read_o & write_o, 0);
         if ((read_o || write_o) && !act_prev) begin
            if (start_q.size() == 0) chk(nm("start_unexp"), 1, 0);
            else begin
               ms = start_q.pop_front();
               chk(nm("start_kind"), read_o, ms.rd);
               chk(nm("start_cyc"), cyc, ms.cyc);
            end
         end
         act_prev <= read_o | write_o;
         if (write_o) begin
            if (beat_q.size() == 0) chk(nm("beat_unexp"), 1, 0);
            else begin
               chk(nm("burst_o"), burst_o, beat_q[0]);
               if (resp_i) void'(beat_q.pop_front());
            end
         end
         if (resp_o) begin
            if (resp_q.size() == 0) chk(nm("resp_unexp"), 1, 0);
            else begin
               mr = resp_q.pop_front();
               chk(nm("resp_cyc"), cyc, mr.cyc);
               chk(nm("resp_rw_low"), read_o | write_o, 0);
               chk(nm("address_o"), address_o, mr.addr);
               if (mr.rd) chk(nm("line_o"), line_o, mr.line);
            end
         end
      end

      // Stimulus program.
      initial begin
         reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
         line_i = '0; address_i = '0; burst_i = '0;
         step(); step();
         reset_n = 1'b1;
         @(negedge clk);
         chk(nm("rst_read_o"), read_o, 0);
         chk(nm("rst_write_o"), write_o, 0);
         chk(nm("rst_resp_o"), resp_o, 0);
         chk(nm("rst_burst_o"), burst_o, 0);
         chk(nm("rst_line_o"), line_o, 0);
         chk(nm("rst_address_o"), address_o, 0);
         step();
         run(1'b1, 1'b0, 32'h0000_1234, '0, 0);
         run(1'b0, 1'b0, 32'h0000_5678, rnd_line(), 1);
         run(1'b1, 1'b1, $urandom, rnd_line(), 0);
         run(1'b0, 1'b0, $urandom, rnd_line(), 0);
         abort_read($urandom);
         run(1'b1, 1'b0, $urandom, '0, 0);
         for (int i = 0; i < 20; i++)
            run(1'($urandom), 1'b0, $urandom, rnd_line(), ($urandom_range(0, 1) != 0) ? 2 : 0);
         step(); step(); step();
         chk(nm("queues_drained"), resp_q.size() + start_q.size() + beat_q.size(), 0);
         done = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000; i++) begin
         if (cfg[0].done && cfg[1].done) break;
         @(posedge clk);
      end
      if (!(cfg[0].done && cfg[1].done)) chk("timeout", 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/burst_line_adapter.md
# burst_line_adapter

Parametrised bridge between the last-level cache and burst-oriented main memory, successor to the fixed 256/64 adapter. Converts one LINE_W-bit cacheline read or write into BEATS = LINE_W/BURST_W memory beats. Beats are acknowledged individually by resp_i and need not be back-to-back. Memory address is line-aligned, and LLC-side data and address are registered at request acceptance.

## Interface
- LINE_W, 256, cacheline width in bits; integer multiple of BURST_W
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W, power of two, ≥ 2
- ADDR_W, 32, byte address width
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- line_i  in  LINE_W  write line from LLC; sampled at acceptance
- line_o  out  LINE_W  read line to LLC; valid while resp_o = 1
- address_i  in  ADDR_W  LLC byte address
- read_i  in  1  LLC line-read request (level)
- write_i  in  1  LLC line-write request (level)
- resp_o  out  1  one-cycle completion pulse to LLC
- burst_i  in  BURST_W  read beat from memory; valid when resp_i = 1
- burst_o  out  BURST_W  write beat to memory
- address_o  out  ADDR_W  line-aligned memory address
- read_o  out  1  memory read request; held for the entire burst
- write_o  out  1  memory write request; held for the entire burst
- resp_i  in  1  memory per-beat acknowledge

## Operation
- States: IDLE, READ, WRITE, DONE. Beat counter cnt has width $clog2(BEATS).
- IDLE: if read_i = 1, go to READ. Otherwise, if write_i = 1, go to WRITE. Read has priority when both are asserted.
- At acceptance:
  - address_o <= address_i with the low $clog2(LINE_W/8) bits forced to 0.
  - cnt <= 0.
  - For a write, capture line_i into an internal buffer.
  - For a read, clear line_o to 0.
- READ:
  - read_o = 1.
  - Each cycle with resp_i = 1: line_o[cnt*BURST_W +: BURST_W] <= burst_i, then cnt++.
  - When resp_i = 1 and cnt = BEATS-1, go to DONE.
  - When resp_i = 0, hold state and cnt.
- WRITE:
  - write_o = 1.
  - burst_o = buffer[cnt*BURST_W +: BURST_W], combinational from cnt; it changes only after an acked beat.
  - Each cycle with resp_i = 1: cnt++. When cnt = BEATS-1 and resp_i = 1, go to DONE.
- DONE:
  - resp_o = 1 for exactly one cycle; read_o = write_o = 0; go to IDLE.
  - line_o is held until the next read acceptance.
- read_i/write_i are ignored outside IDLE. A request still asserted in the IDLE cycle after DONE counts as a new request, so the LLC must drop it on seeing resp_o.
- read_o, write_o and resp_o are decoded from registered state only, so they are glitch-free.
- burst_o = 0 when not in WRITE.
- resp_i is ignored in IDLE and DONE.

## Timing
- Reset (reset_n = 0 at a clk edge): state = IDLE, cnt = 0, line_o = 0, buffer = 0, address_o = 0. This makes read_o = write_o = resp_o = 0 and burst_o = 0.
- Reset mid-burst aborts immediately: the memory request drops the next cycle and no resp_o is issued.
- Request seen in IDLE at cycle 0 → read_o/write_o high from cycle 1.
- With resp_i high every cycle from cycle 1, resp_o is high at cycle BEATS+1; default minimum is 5 cycles.
- Each cycle with resp_i = 0 during the burst adds one cycle of latency.
- Back-to-back: the earliest next acceptance is the IDLE cycle directly after DONE, so the minimum request-to-request period is BEATS+2 cycles.
- address_o is stable from cycle 1 until the next acceptance.

## Test plan
- Default params, read of address_i = 0x0000_1234, burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i → address_o = 0x0000_1220; resp_o only at cycle 5; line_o = {0x44..,0x33..,0x22..,0x11..}; read_o falls at cycle 5.
- Write of line_i = {D3,D2,D1,D0}, with resp_i high in cycles 1, 3, 4, 7 → burst_o = D0 through cycle 1, then D1, D2, D3 after each ack; resp_o at cycle 8; write_o = 1 in cycles 1–7.
- read_i and write_i asserted together → READ taken; write_o never asserts; after resp_o, with write_i still high, a write starts from the next IDLE cycle.
- reset_n = 0 after 2 read beats → next cycle read_o = 0, resp_o = 0, line_o = 0; a fresh read then completes normally with cnt restarting at 0.
- LINE_W = 512, BURST_W = 64 (BEATS = 8), read with continuous acks → resp_o at cycle 9; all 8 beats land in the correct slices; address low 6 bits = 0.
- line_i changed during a write burst → burst_o still carries the line captured at acceptance.
